// File: rtl/mm_seq_if.sv
// mm_seq_if: control bus between the modexp FSM, the Montgomery sequencer and
// the multiplier pipeline / word RAMs.
//   start, op          : operation request from the top-level FSM
//   busy, done         : sequencer status
//   rd_en, *_addr      : operand RAM read port (1-cycle synchronous read)
//   pipe_ce/cp/init    : pipeline strobes, aligned with RAM read data
//   d_zero, ab_zero    : operand gating, aligned with RAM read data
//   res_we, res_addr   : result write into the D RAM, aligned with D_o
// master = sequencer side, slave = environment side.
interface mm_seq_if #(
    parameter int N_WORDS = 64
);
    localparam int AW = $clog2(N_WORDS);

    logic          start;
    logic          op;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] d_addr;
    logic          pipe_ce;
    logic          pipe_cp;
    logic          pipe_init;
    logic          d_zero;
    logic          ab_zero;
    logic          res_we;
    logic [AW-1:0] res_addr;

    modport master (
        input  start, op,
        output busy, done, rd_en, a_addr, b_addr, m_addr, d_addr,
               pipe_ce, pipe_cp, pipe_init, d_zero, ab_zero, res_we, res_addr
    );

    modport slave (
        output start, op,
        input  busy, done, rd_en, a_addr, b_addr, m_addr, d_addr,
               pipe_ce, pipe_cp, pipe_init, d_zero, ab_zero, res_we, res_addr
    );
endinterface

// File: rtl/mm_seq.sv
// mm_seq: word-serial CIOS sequencer for the radix-2^16 Montgomery pipeline.
// Walks (i,j) over e = N_WORDS words (j inner), then one flush beat; or walks
// j for a copy of A into D. Issue-stage outputs (rd_en, addresses) come
// straight from the state/counters; pipeline strobes are registered one cycle
// later to line up with RAM data; write strobes ride a PIPE_LAT+1 deep delay
// line to line up with the pipeline output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mm_seq_if.master (see interface header)
module mm_seq #(
    parameter int N_WORDS  = 64,
    parameter int PIPE_LAT = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    mm_seq_if.master bus
);
    localparam int            AW   = $clog2(N_WORDS);
    localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);

    // Write-before-read on D needs the operand long enough to cover the
    // pipeline latency plus RAM read and write registers.
    if (N_WORDS < PIPE_LAT + 3 || PIPE_LAT < 1) begin : g_bad_params
        $error("mm_seq: need N_WORDS >= PIPE_LAT+3 and PIPE_LAT >= 1");
    end

    typedef enum logic [2:0] {IDLE, MUL, FLUSH, COPY, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] i_q, j_q, i_nx, j_nx;

    // issue-stage signals (cycle the addresses are on the RAM port)
    logic          iss;
    logic [AW-1:0] a_addr, b_addr, m_addr, d_addr;
    logic          iss_init, iss_cp, iss_dz, iss_abz;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;

    // aligned-stage registers (cycle the RAM data is at the pipeline input)
    logic          ce_q, init_q, cp_q, dz_q, abz_q;

    // write tag delay line: bit 0 is the aligned stage, bit PIPE_LAT is D_o
    logic [PIPE_LAT:0]         vld_pipe;
    logic [PIPE_LAT:0][AW-1:0] tag_pipe;

    always_comb begin
        state_nx = state;
        i_nx     = i_q;
        j_nx     = j_q;
        iss      = 1'b0;
        a_addr   = '0;
        b_addr   = '0;
        m_addr   = '0;
        d_addr   = '0;
        iss_init = 1'b0;
        iss_cp   = 1'b0;
        iss_dz   = 1'b0;
        iss_abz  = 1'b0;
        wr_vld   = 1'b0;
        wr_addr  = '0;
        case (state)
            IDLE: begin
                i_nx = '0;
                j_nx = '0;
                if (bus.start) state_nx = bus.op ? COPY : MUL;
            end
            MUL: begin
                iss      = 1'b1;
                a_addr   = j_q;
                b_addr   = i_q;
                m_addr   = j_q;
                d_addr   = j_q;
                iss_init = (j_q == '0);
                iss_dz   = (i_q == '0);
                // beat (i,j>0) emits D[j-1]; beat (i>0,0) emits D[e-1] of i-1
                wr_vld   = (j_q != '0) || (i_q != '0);
                wr_addr  = (j_q != '0) ? j_q - AW'(1) : LAST;
                if (j_q == LAST) begin
                    j_nx = '0;
                    i_nx = i_q + AW'(1);
                    if (i_q == LAST) state_nx = FLUSH;
                end else begin
                    j_nx = j_q + AW'(1);
                end
            end
            FLUSH: begin
                // zero-operand beat that pushes out D[e-1] of the last row
                iss      = 1'b1;
                iss_init = 1'b1;
                iss_dz   = 1'b1;
                iss_abz  = 1'b1;
                wr_vld   = 1'b1;
                wr_addr  = LAST;
                state_nx = DRAIN;
            end
            COPY: begin
                iss     = 1'b1;
                a_addr  = j_q;
                iss_cp  = 1'b1;
                iss_dz  = 1'b1;
                wr_vld  = 1'b1;
                wr_addr = j_q;
                if (j_q == LAST) begin
                    j_nx     = '0;
                    state_nx = DRAIN;
                end else begin
                    j_nx = j_q + AW'(1);
                end
            end
            DRAIN: begin
                // only the write at D_o (if any) is left in flight
                if (vld_pipe[PIPE_LAT-1:0] == '0) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            ce_q     <= 1'b0;
            init_q   <= 1'b0;
            cp_q     <= 1'b0;
            dz_q     <= 1'b0;
            abz_q    <= 1'b0;
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            state  <= state_nx;
            i_q    <= i_nx;
            j_q    <= j_nx;
            // ce rises with the first aligned beat and holds through DONE
            if (state == DONE) ce_q <= 1'b0;
            else if (iss)      ce_q <= 1'b1;
            init_q   <= iss_init;
            cp_q     <= iss_cp;
            dz_q     <= iss_dz;
            abz_q    <= iss_abz;
            vld_pipe <= {vld_pipe[PIPE_LAT-1:0], wr_vld};
            tag_pipe <= {tag_pipe[PIPE_LAT-1:0], wr_addr};
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.rd_en     = iss;
    assign bus.a_addr    = a_addr;
    assign bus.b_addr    = b_addr;
    assign bus.m_addr    = m_addr;
    assign bus.d_addr    = d_addr;
    assign bus.pipe_ce   = ce_q;
    assign bus.pipe_cp   = cp_q;
    assign bus.pipe_init = init_q;
    assign bus.d_zero    = dz_q;
    assign bus.ab_zero   = abz_q;
    assign bus.res_we    = vld_pipe[PIPE_LAT];
    assign bus.res_addr  = vld_pipe[PIPE_LAT] ? tag_pipe[PIPE_LAT] : '0;
endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: directed bench for mm_seq at N_WORDS=16, PIPE_LAT=8.
// Cycle c is counted from the cycle start is presented (c=0); outputs are
// sampled 2 time units after each rising edge. Expected values are the
// schedule timing written out per cycle.
module tb_mm_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mm_seq_if #(.N_WORDS(16)) bus();

    mm_seq #(.N_WORDS(16), .PIPE_LAT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       busy, done, rd_en;
        logic [3:0] a, b, m, d;
        logic       ce, cp, init, dz, abz, we;
        logic [3:0] ra;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string sc, input int c, input exp_t e);
        chk($sformatf("%s@%0d busy", sc, c),      32'(bus.busy),      32'(e.busy));
        chk($sformatf("%s@%0d done", sc, c),      32'(bus.done),      32'(e.done));
        chk($sformatf("%s@%0d rd_en", sc, c),     32'(bus.rd_en),     32'(e.rd_en));
        chk($sformatf("%s@%0d a_addr", sc, c),    32'(bus.a_addr),    32'(e.a));
        chk($sformatf("%s@%0d b_addr", sc, c),    32'(bus.b_addr),    32'(e.b));
        chk($sformatf("%s@%0d m_addr", sc, c),    32'(bus.m_addr),    32'(e.m));
        chk($sformatf("%s@%0d d_addr", sc, c),    32'(bus.d_addr),    32'(e.d));
        chk($sformatf("%s@%0d pipe_ce", sc, c),   32'(bus.pipe_ce),   32'(e.ce));
        chk($sformatf("%s@%0d pipe_cp", sc, c),   32'(bus.pipe_cp),   32'(e.cp));
        chk($sformatf("%s@%0d pipe_init", sc, c), 32'(bus.pipe_init), 32'(e.init));
        chk($sformatf("%s@%0d d_zero", sc, c),    32'(bus.d_zero),    32'(e.dz));
        chk($sformatf("%s@%0d ab_zero", sc, c),   32'(bus.ab_zero),   32'(e.abz));
        chk($sformatf("%s@%0d res_we", sc, c),    32'(bus.res_we),    32'(e.we));
        if (e.we)
            chk($sformatf("%s@%0d res_addr", sc, c), 32'(bus.res_addr), 32'(e.ra));
    endtask

    function automatic exp_t exp_copy(input int c);
        exp_t e = '0;
        e.busy  = (c >= 1 && c <= 26);
        e.done  = (c == 26);
        e.rd_en = (c >= 1 && c <= 16);
        e.a     = e.rd_en ? 4'(c - 1) : 4'd0;
        e.ce    = (c >= 2 && c <= 26);
        e.cp    = (c >= 2 && c <= 17);
        e.dz    = (c >= 2 && c <= 17);
        e.we    = (c >= 10 && c <= 25);
        e.ra    = e.we ? 4'(c - 10) : 4'd0;
        return e;
    endfunction

    function automatic exp_t exp_mul(input int c);
        exp_t e = '0;
        int   k;
        e.busy  = (c >= 1 && c <= 267);
        e.done  = (c == 267);
        e.rd_en = (c >= 1 && c <= 257);
        if (c >= 1 && c <= 256) begin
            e.a = 4'((c - 1) % 16);
            e.m = e.a;
            e.d = e.a;
            e.b = 4'((c - 1) / 16);
        end
        e.ce   = (c >= 2 && c <= 267);
        k      = c - 1;   // beat whose data is aligned this cycle
        e.init = (k >= 1 && k <= 256 && (k - 1) % 16 == 0) || (c == 258);
        e.dz   = (c >= 2 && c <= 17) || (c == 258);
        e.abz  = (c == 258);
        e.we   = (c >= 11 && c <= 266);
        k      = c - 9;   // beat whose result is at D_o this cycle
        if (e.we) begin
            if (k == 257 || (k - 1) % 16 == 0) e.ra = 4'd15;
            else                               e.ra = 4'((k - 1) % 16 - 1);
        end
        return e;
    endfunction

    // Presents start in the current cycle (c=0) and checks cycles 1..27.
    task automatic run_copy(input string sc);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            if (c == 1) bus.start = 1'b0;
            chk_outs(sc, c, exp_copy(c));
        end
    endtask

    // Multiply from c=0; optional colliding copy request at c=100;
    // stop_at < 268 abandons the run after checking that cycle.
    task automatic run_mul(input string sc, input bit collide, input int stop_at);
        int nwr = 0;
        int ninit = 0;
        bus.start = 1'b1;
        bus.op    = 1'b0;
        for (int c = 1; c <= stop_at; c++) begin
            tick();
            bus.start = 1'b0;
            if (collide && c == 100) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
            end
            chk_outs(sc, c, exp_mul(c));
            if (bus.res_we)    nwr++;
            if (bus.pipe_init) ninit++;
        end
        if (stop_at == 268) begin
            chk($sformatf("%s write count", sc), 32'(nwr), 32'd256);
            chk($sformatf("%s init count", sc), 32'(ninit), 32'd17);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;

        // reset held: start must be ignored, everything stays 0
        tick();
        bus.start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_outs("rst_hold", c, exp_t'(0));
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_outs("rst_rel", c, exp_t'(0));
        end

        // copy, then a multiply started in the first IDLE cycle after done
        run_copy("copy");
        run_mul("mul", 1'b0, 268);

        // multiply with an ignored copy request mid-run
        tick();
        run_mul("collide", 1'b1, 268);

        // reset mid-multiply: outputs drop without a clock edge
        tick();
        run_mul("mul_rst", 1'b0, 150);
        #1 rst_n = 1'b0;
        #1 chk_outs("rst_async", 150, exp_t'(0));
        for (int c = 151; c < 154; c++) begin
            tick();
            chk_outs("rst_mid", c, exp_t'(0));
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_outs("rst_after", c, exp_t'(0));
        end
        run_copy("copy2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
